// File: rtl/calc_sequencer.sv
// Button-driven accumulator calculator sequencing an external adder/subtractor.
// Define CALC_SATURATE_EN to saturate the accumulator on overflow instead of wrapping.
module calc_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic pulse
);
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          hit;

    // Toggle on the DB_CYCLES-th consecutive mismatching sample.
    assign hit   = (raw != level_q) && (cnt_q == LAST);
    assign pulse = hit && raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else if (raw == level_q) begin
            cnt_q <= '0;
        end else if (hit) begin
            level_q <= raw;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + ONE;
        end
    end
endmodule

module calc_sequencer #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             op_sub,
    input  logic             interp,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_sovf,
    input  logic             alu_uovf,
    output logic [WIDTH-1:0] acc,
    output logic             ovf_flag,
    output logic             disp_sel,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        EXEC  = 2'b10,
        SHOW  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             ovf_q, ovf_d;
    logic             enter_p, clear_p;
    logic             sel_ovf;
    logic [WIDTH-1:0] result;

    calc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_enter (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (btn_enter),
        .pulse  (enter_p)
    );

    calc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (btn_clear),
        .pulse  (clear_p)
    );

    assign sel_ovf = interp ? alu_sovf : alu_uovf;

`ifdef CALC_SATURATE_EN
    // Signed overflow direction follows the accumulator sign.
    always_comb begin
        result = alu_res;
        if (sel_ovf) begin
            if (interp)
                result = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
            else
                result = sub_q ? '0 : '1;
        end
    end
`else
    assign result = alu_res;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        sub_d   = sub_q;
        ovf_d   = ovf_q;
        if (clear_p) begin
            state_d = IDLE;
            acc_d   = '0;
            b_d     = '0;
            sub_d   = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enter_p) begin
                        acc_d   = sw;
                        state_d = ARMED;
                    end
                end
                ARMED, SHOW: begin
                    if (enter_p) begin
                        b_d     = sw;
                        sub_d   = op_sub;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    acc_d   = result;
                    ovf_d   = ovf_q | sel_ovf;
                    state_d = SHOW;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            ovf_q   <= ovf_d;
        end
    end

    assign alu_a    = acc_q;
    assign alu_b    = b_q;
    assign alu_sub  = sub_q;
    assign acc      = acc_q;
    assign ovf_flag = ovf_q;
    assign disp_sel = (state_q == SHOW);
    assign state    = state_q;
endmodule
